// File: rtl/vec_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : vec_mem_access
//  Purpose  : Memory-stage sequencer behind the EX/MEM pipeline register.
//             Splits scalar (1-word) and vector (4-word) loads/stores into
//             single-word transactions on a ready-handshaked data-memory
//             port, stalls the upstream pipeline for the duration of the
//             access and presents load results to the MEM/WB side.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk                  clock, all state updates on the rising edge
//    reset                asynchronous active-low reset
//    wr_mem_in/rd_mem_in  store/load request from EX/MEM (store wins if both)
//    vec_op_in            1 = 4-lane vector access, 0 = scalar access
//    store_address_in     base byte address
//    scalar_result_in     scalar store data
//    v1in..v4in           vector store data, lanes 0..3
//    mem_addr/mem_wdata   memory word address / write data
//    mem_we/mem_re        memory write / read strobes
//    mem_rdata/mem_ready  memory read data / transaction-complete handshake
//    stall                hold PC, IF/ID, ID/EX, EX/MEM
//    ld_valid             one-cycle pulse when load results were updated
//    ld_scalar_out        scalar load result
//    ld_v1out..ld_v4out   vector load result, lanes 0..3
// ============================================================================
module vec_mem_access #(
    parameter int DATA_W    = 32,
    parameter int ADDR_STEP = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_mem_in,
    input  logic              rd_mem_in,
    input  logic              vec_op_in,
    input  logic [DATA_W-1:0] store_address_in,
    input  logic [DATA_W-1:0] scalar_result_in,
    input  logic [DATA_W-1:0] v1in,
    input  logic [DATA_W-1:0] v2in,
    input  logic [DATA_W-1:0] v3in,
    input  logic [DATA_W-1:0] v4in,
    output logic [DATA_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic              stall,
    output logic              ld_valid,
    output logic [DATA_W-1:0] ld_scalar_out,
    output logic [DATA_W-1:0] ld_v1out,
    output logic [DATA_W-1:0] ld_v2out,
    output logic [DATA_W-1:0] ld_v3out,
    output logic [DATA_W-1:0] ld_v4out
);

    localparam logic [DATA_W-1:0] C_STEP     = DATA_W'(ADDR_STEP);
    localparam logic [1:0]        C_LAST_LANE = 2'd3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t r_state;
    state_t w_next_state;

    // Captured request context (held for the whole access so that the
    // upstream pipeline register is free to be stalled or change)
    logic              r_is_store;
    logic              r_is_vec;
    logic [1:0]        r_lane;
    logic [DATA_W-1:0] r_base;
    logic [DATA_W-1:0] r_sdata;
    logic [DATA_W-1:0] r_vdata [4];

    // Load result registers
    logic [DATA_W-1:0] r_ld_scalar;
    logic [DATA_W-1:0] r_ld_v [4];

    logic              w_req;
    logic              w_accept;
    logic              w_beat;
    logic              w_last_beat;
    logic [DATA_W-1:0] w_offset;
    logic [DATA_W-1:0] w_lane_addr;
    logic [DATA_W-1:0] w_lane_wdata;

    assign w_req = wr_mem_in | rd_mem_in;

    // Byte offset of the current lane; the add wraps modulo 2^DATA_W.
    assign w_offset     = DATA_W'(r_lane) * C_STEP;
    assign w_lane_addr  = r_base + w_offset;
    assign w_lane_wdata = r_is_vec ? r_vdata[r_lane] : r_sdata;
    assign w_last_beat  = !r_is_vec || (r_lane == C_LAST_LANE);

    // ------------------------------------------------------------------
    // Next-state and output decode
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        w_accept     = 1'b0;
        w_beat       = 1'b0;
        stall        = 1'b0;
        mem_we       = 1'b0;
        mem_re       = 1'b0;
        mem_addr     = '0;
        mem_wdata    = '0;
        ld_valid     = 1'b0;

        case (r_state)
            IDLE: begin
                if (w_req) begin
                    w_accept     = 1'b1;
                    // stall is combinational from the request inputs, so
                    // it is qualified with reset to keep every output low
                    // while reset is asserted.
                    stall        = reset;
                    w_next_state = ACCESS;
                end
            end

            ACCESS: begin
                stall    = 1'b1;
                mem_addr = w_lane_addr;
                if (r_is_store) begin
                    mem_we    = 1'b1;
                    mem_wdata = w_lane_wdata;
                end else begin
                    mem_re = 1'b1;
                end
                if (mem_ready) begin
                    w_beat = 1'b1;
                    if (w_last_beat) begin
                        w_next_state = DONE;
                    end
                end
            end

            DONE: begin
                // Requests still visible here belong to the instruction
                // that is just completing, so they are never accepted.
                ld_valid     = !r_is_store;
                w_next_state = IDLE;
            end

            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // Request capture and lane counter
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_is_store <= 1'b0;
            r_is_vec   <= 1'b0;
            r_lane     <= 2'd0;
            r_base     <= '0;
            r_sdata    <= '0;
            for (int i = 0; i < 4; i++) begin
                r_vdata[i] <= '0;
            end
        end else begin
            if (w_accept) begin
                // A simultaneous load request is dropped: store wins.
                r_is_store <= wr_mem_in;
                r_is_vec   <= vec_op_in;
                r_lane     <= 2'd0;
                r_base     <= store_address_in;
                r_sdata    <= scalar_result_in;
                r_vdata[0] <= v1in;
                r_vdata[1] <= v2in;
                r_vdata[2] <= v3in;
                r_vdata[3] <= v4in;
            end else if (w_beat) begin
                r_lane <= r_lane + 2'd1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Load result registers: only the lane being completed is written, so
    // a scalar load leaves the vector lanes untouched and vice versa.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_ld_scalar <= '0;
            for (int i = 0; i < 4; i++) begin
                r_ld_v[i] <= '0;
            end
        end else if (w_beat && !r_is_store) begin
            if (r_is_vec) begin
                r_ld_v[r_lane] <= mem_rdata;
            end else begin
                r_ld_scalar <= mem_rdata;
            end
        end
    end

    assign ld_scalar_out = r_ld_scalar;
    assign ld_v1out      = r_ld_v[0];
    assign ld_v2out      = r_ld_v[1];
    assign ld_v3out      = r_ld_v[2];
    assign ld_v4out      = r_ld_v[3];

endmodule
`default_nettype wire

// File: tb/tb_vec_mem_access.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vec_mem_access
//  Purpose  : Directed self-checking bench for vec_mem_access. A memory
//             responder returns data indexed by address bits [3:2] after a
//             programmable number of wait cycles; a monitor logs completed
//             transactions, stall cycles, ld_valid pulses and any change of
//             address/data/strobe while a transaction is waiting.
//  Revision : 1.0  initial release
// ============================================================================
module tb_vec_mem_access;

    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          reset;
    logic          wr_mem_in, rd_mem_in, vec_op_in;
    logic [DW-1:0] store_address_in, scalar_result_in;
    logic [DW-1:0] v1in, v2in, v3in, v4in;
    logic [DW-1:0] mem_addr, mem_wdata;
    logic          mem_we, mem_re;
    logic [DW-1:0] mem_rdata = '0;
    logic          mem_ready = 1'b0;
    logic          stall, ld_valid;
    logic [DW-1:0] ld_scalar_out, ld_v1out, ld_v2out, ld_v3out, ld_v4out;

    vec_mem_access #(.DATA_W(DW), .ADDR_STEP(4)) dut (
        .clk              (clk),
        .reset            (reset),
        .wr_mem_in        (wr_mem_in),
        .rd_mem_in        (rd_mem_in),
        .vec_op_in        (vec_op_in),
        .store_address_in (store_address_in),
        .scalar_result_in (scalar_result_in),
        .v1in             (v1in),
        .v2in             (v2in),
        .v3in             (v3in),
        .v4in             (v4in),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_we           (mem_we),
        .mem_re           (mem_re),
        .mem_rdata        (mem_rdata),
        .mem_ready        (mem_ready),
        .stall            (stall),
        .ld_valid         (ld_valid),
        .ld_scalar_out    (ld_scalar_out),
        .ld_v1out         (ld_v1out),
        .ld_v2out         (ld_v2out),
        .ld_v3out         (ld_v3out),
        .ld_v4out         (ld_v4out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Responder configuration (written only by the test tasks)
    int            wait_cfg    = 0;
    logic          force_ready = 1'b0;
    logic [DW-1:0] rdata_tbl [4];

    // Monitor state (written only by the monitor)
    int            stall_cnt = 0;
    int            lv_cnt    = 0;
    int            unstable  = 0;
    int            n_log     = 0;
    logic [DW-1:0] log_addr [64];
    logic [DW-1:0] log_data [64];
    logic          log_we   [64];

    // Memory responder: updates mem_ready/mem_rdata on the falling edge.
    int wcnt = 0;
    always @(negedge clk) begin
        if (mem_we || mem_re) begin
            if (wcnt >= wait_cfg) begin
                mem_ready = 1'b1;
                mem_rdata = rdata_tbl[mem_addr[3:2]];
                wcnt      = 0;
            end else begin
                mem_ready = 1'b0;
                wcnt      = wcnt + 1;
            end
        end else begin
            mem_ready = force_ready;
            wcnt      = 0;
        end
    end

    // Monitor: samples 1 ns after the falling edge.
    logic          in_txn = 1'b0;
    logic [DW-1:0] p_addr, p_data;
    logic          p_we;
    always @(negedge clk) begin
        #1;
        if (stall)    stall_cnt = stall_cnt + 1;
        if (ld_valid) lv_cnt    = lv_cnt + 1;
        if (mem_we || mem_re) begin
            if (in_txn && (mem_addr !== p_addr || mem_wdata !== p_data || mem_we !== p_we))
                unstable = unstable + 1;
            if (mem_ready) begin
                if (n_log < 64) begin
                    log_addr[n_log] = mem_addr;
                    log_data[n_log] = mem_wdata;
                    log_we[n_log]   = mem_we;
                end
                n_log  = n_log + 1;
                in_txn = 1'b0;
            end else begin
                in_txn = 1'b1;
                p_addr = mem_addr;
                p_data = mem_wdata;
                p_we   = mem_we;
            end
        end else begin
            in_txn = 1'b0;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clear_req();
        wr_mem_in = 1'b0;
        rd_mem_in = 1'b0;
        vec_op_in = 1'b0;
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset();
        int b;
        reset = 1'b0; force_ready = 1'b1;
        wr_mem_in = 1'b1; rd_mem_in = 1'b1; vec_op_in = 1'b0;
        store_address_in = 32'h80; scalar_result_in = 32'h1234_5678;
        v1in = '0; v2in = '0; v3in = '0; v4in = '0;
        tick(3);
        #2;
        total++; if ({mem_we, mem_re, stall, ld_valid} !== 4'b0) begin bad++;
            $display("FAIL reset_ctrl: got %b want 0000", {mem_we, mem_re, stall, ld_valid}); end
        total++; if ({mem_addr, mem_wdata} !== 64'h0) begin bad++;
            $display("FAIL reset_bus: got %h %h want 0", mem_addr, mem_wdata); end
        total++; if ({ld_scalar_out, ld_v1out, ld_v2out, ld_v3out, ld_v4out} !== 160'h0) begin bad++;
            $display("FAIL reset_ld: got %h %h %h %h %h want 0", ld_scalar_out, ld_v1out, ld_v2out, ld_v3out, ld_v4out); end
        // Release with a one-cycle request (store wins over load).
        @(negedge clk);
        b = n_log;
        reset = 1'b1;
        @(negedge clk);
        clear_req();
        tick(6);
        force_ready = 1'b0;
        total++; if (n_log - b !== 1) begin bad++;
            $display("FAIL reset_once: got %0d txns want 1", n_log - b); end
        total++; if ({log_we[b], log_addr[b], log_data[b]} !== {1'b1, 32'h80, 32'h1234_5678}) begin bad++;
            $display("FAIL reset_txn: got we=%b %h %h want we=1 00000080 12345678", log_we[b], log_addr[b], log_data[b]); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scalar_store();
        int b, s, l;
        wait_cfg = 0;
        @(negedge clk);
        b = n_log; s = stall_cnt; l = lv_cnt;
        wr_mem_in = 1'b1; store_address_in = 32'h100; scalar_result_in = 32'hDEAD_BEEF;
        @(negedge clk);
        clear_req();
        tick(5);
        total++; if (n_log - b !== 1) begin bad++;
            $display("FAIL sst_count: got %0d want 1", n_log - b); end
        total++; if ({log_we[b], log_addr[b], log_data[b]} !== {1'b1, 32'h100, 32'hDEAD_BEEF}) begin bad++;
            $display("FAIL sst_txn: got we=%b %h %h want we=1 00000100 deadbeef", log_we[b], log_addr[b], log_data[b]); end
        total++; if (stall_cnt - s !== 2) begin bad++;
            $display("FAIL sst_stall: got %0d want 2", stall_cnt - s); end
        total++; if (lv_cnt - l !== 0) begin bad++;
            $display("FAIL sst_ldvalid: got %0d want 0", lv_cnt - l); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_vector_load();
        int b, s, l, u;
        logic [DW-1:0] exp_a [4];
        exp_a[0] = 32'h200; exp_a[1] = 32'h204; exp_a[2] = 32'h208; exp_a[3] = 32'h20C;
        rdata_tbl[0] = 32'h11; rdata_tbl[1] = 32'h22; rdata_tbl[2] = 32'h33; rdata_tbl[3] = 32'h44;
        wait_cfg = 2;
        @(negedge clk);
        b = n_log; s = stall_cnt; l = lv_cnt; u = unstable;
        rd_mem_in = 1'b1; vec_op_in = 1'b1; store_address_in = 32'h200;
        @(negedge clk);
        clear_req();
        tick(18);
        total++; if (n_log - b !== 4) begin bad++;
            $display("FAIL vld_count: got %0d want 4", n_log - b); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({log_we[b+i], log_addr[b+i]} !== {1'b0, exp_a[i]}) begin bad++;
                $display("FAIL vld_addr%0d: got we=%b %h want we=0 %h", i, log_we[b+i], log_addr[b+i], exp_a[i]); end
        end
        total++; if ({ld_v1out, ld_v2out, ld_v3out, ld_v4out} !== {32'h11, 32'h22, 32'h33, 32'h44}) begin bad++;
            $display("FAIL vld_data: got %h %h %h %h want 11 22 33 44", ld_v1out, ld_v2out, ld_v3out, ld_v4out); end
        total++; if (stall_cnt - s !== 13) begin bad++;
            $display("FAIL vld_stall: got %0d want 13", stall_cnt - s); end
        total++; if (lv_cnt - l !== 1) begin bad++;
            $display("FAIL vld_ldvalid: got %0d want 1", lv_cnt - l); end
        total++; if (unstable - u !== 0) begin bad++;
            $display("FAIL vld_stable: got %0d changes want 0", unstable - u); end
        total++; if (ld_scalar_out !== 32'h0) begin bad++;
            $display("FAIL vld_scalar_kept: got %h want 0", ld_scalar_out); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_scalar_load();
        int s, l;
        rdata_tbl[1] = 32'h5A5A_0001;
        wait_cfg = 1;
        @(negedge clk);
        s = stall_cnt; l = lv_cnt;
        rd_mem_in = 1'b1; store_address_in = 32'h34;
        @(negedge clk);
        clear_req();
        tick(6);
        total++; if (ld_scalar_out !== 32'h5A5A_0001) begin bad++;
            $display("FAIL sld_data: got %h want 5a5a0001", ld_scalar_out); end
        total++; if ({ld_v1out, ld_v4out} !== {32'h11, 32'h44}) begin bad++;
            $display("FAIL sld_lanes_kept: got %h %h want 11 44", ld_v1out, ld_v4out); end
        total++; if (stall_cnt - s !== 3) begin bad++;
            $display("FAIL sld_stall: got %0d want 3", stall_cnt - s); end
        total++; if (lv_cnt - l !== 1) begin bad++;
            $display("FAIL sld_ldvalid: got %0d want 1", lv_cnt - l); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_vector_store_wrap();
        int b, s;
        logic [DW-1:0] exp_a [4];
        logic [DW-1:0] exp_d [4];
        exp_a[0] = 32'hFFFF_FFF8; exp_a[1] = 32'hFFFF_FFFC; exp_a[2] = 32'h0; exp_a[3] = 32'h4;
        exp_d[0] = 32'hA000_0001; exp_d[1] = 32'hB000_0002; exp_d[2] = 32'hC000_0003; exp_d[3] = 32'hD000_0004;
        wait_cfg = 0;
        @(negedge clk);
        b = n_log; s = stall_cnt;
        wr_mem_in = 1'b1; vec_op_in = 1'b1; store_address_in = 32'hFFFF_FFF8;
        scalar_result_in = 32'h9999_9999;
        v1in = exp_d[0]; v2in = exp_d[1]; v3in = exp_d[2]; v4in = exp_d[3];
        @(negedge clk);
        clear_req();
        v1in = '0; v2in = '0; v3in = '0; v4in = '0;
        tick(8);
        total++; if (n_log - b !== 4) begin bad++;
            $display("FAIL vst_count: got %0d want 4", n_log - b); end
        for (int i = 0; i < 4; i++) begin
            total++; if ({log_we[b+i], log_addr[b+i], log_data[b+i]} !== {1'b1, exp_a[i], exp_d[i]}) begin bad++;
                $display("FAIL vst_lane%0d: got we=%b %h %h want we=1 %h %h", i, log_we[b+i], log_addr[b+i], log_data[b+i], exp_a[i], exp_d[i]); end
        end
        total++; if (stall_cnt - s !== 5) begin bad++;
            $display("FAIL vst_stall: got %0d want 5", stall_cnt - s); end
        total++; if ({ld_scalar_out, ld_v1out, ld_v3out} !== {32'h5A5A_0001, 32'h11, 32'h33}) begin bad++;
            $display("FAIL vst_ld_untouched: got %h %h %h want 5a5a0001 11 33", ld_scalar_out, ld_v1out, ld_v3out); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_both_requests();
        int b, s, l, nre;
        wait_cfg = 0;
        @(negedge clk);
        b = n_log; s = stall_cnt; l = lv_cnt;
        wr_mem_in = 1'b1; rd_mem_in = 1'b1; vec_op_in = 1'b0;
        store_address_in = 32'h40; scalar_result_in = 32'hCAFE_F00D;
        // Hold through IDLE, ACCESS and DONE; drop before the next IDLE edge.
        tick(3);
        clear_req();
        tick(5);
        nre = 0;
        for (int i = b; i < n_log; i++) if (!log_we[i]) nre++;
        total++; if (n_log - b !== 1) begin bad++;
            $display("FAIL both_count: got %0d want 1", n_log - b); end
        total++; if ({log_we[b], log_addr[b], log_data[b]} !== {1'b1, 32'h40, 32'hCAFE_F00D}) begin bad++;
            $display("FAIL both_txn: got we=%b %h %h want we=1 00000040 cafef00d", log_we[b], log_addr[b], log_data[b]); end
        total++; if (nre !== 0) begin bad++;
            $display("FAIL both_no_read: got %0d reads want 0", nre); end
        total++; if (lv_cnt - l !== 0) begin bad++;
            $display("FAIL both_ldvalid: got %0d want 0", lv_cnt - l); end
        total++; if (stall_cnt - s !== 2) begin bad++;
            $display("FAIL both_stall: got %0d want 2", stall_cnt - s); end
    endtask

    // ------------------------------------------------------------------
    task automatic test_reset_mid_access();
        int b, l;
        rdata_tbl[0] = 32'hA1; rdata_tbl[1] = 32'hA2; rdata_tbl[2] = 32'hA3; rdata_tbl[3] = 32'hA4;
        wait_cfg = 1;
        @(negedge clk);
        b = n_log; l = lv_cnt;
        rd_mem_in = 1'b1; vec_op_in = 1'b1; store_address_in = 32'h300;
        @(negedge clk);
        clear_req();
        // Lanes 0 and 1 take two cycles each; now in the wait cycle of lane 2.
        tick(4);
        #3;
        total++; if ({mem_re, mem_addr, ld_v2out} !== {1'b1, 32'h308, 32'hA2}) begin bad++;
            $display("FAIL mid_prefix: got re=%b %h %h want re=1 00000308 000000a2", mem_re, mem_addr, ld_v2out); end
        reset = 1'b0;
        #1;
        total++; if ({mem_re, mem_we, stall} !== 3'b000) begin bad++;
            $display("FAIL mid_strobes: got %b want 000", {mem_re, mem_we, stall}); end
        total++; if ({ld_v1out, ld_v2out, ld_v3out, ld_v4out, ld_scalar_out} !== 160'h0) begin bad++;
            $display("FAIL mid_ld_clear: got %h %h %h %h %h want 0", ld_v1out, ld_v2out, ld_v3out, ld_v4out, ld_scalar_out); end
        tick(3);
        reset = 1'b1;
        tick(4);
        total++; if (n_log - b !== 2) begin bad++;
            $display("FAIL mid_count: got %0d want 2", n_log - b); end
        total++; if (lv_cnt - l !== 0) begin bad++;
            $display("FAIL mid_ldvalid: got %0d want 0", lv_cnt - l); end
        total++; if ({ld_v3out, ld_v4out, stall} !== {32'h0, 32'h0, 1'b0}) begin bad++;
            $display("FAIL mid_after: got %h %h stall=%b want 0 0 0", ld_v3out, ld_v4out, stall); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) rdata_tbl[i] = '0;
        test_reset();
        test_scalar_store();
        test_vector_load();
        test_scalar_load();
        test_vector_store_wrap();
        test_both_requests();
        test_reset_mid_access();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
